// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: request entry layout,
// host FIFO geometry and the default starvation threshold.
package dmem_arb_pkg;

  localparam int ARB_AW           = 12;  // word-address width (4096 words)
  localparam int ARB_DW           = 32;  // data width
  localparam int FIFO_DEPTH       = 2;   // buffered host requests
  localparam int FIFO_CW          = $clog2(FIFO_DEPTH + 1);  // holds 0..FIFO_DEPTH
  localparam int FIFO_PW          = $clog2(FIFO_DEPTH);      // pointer width
  localparam int STARVE_LIMIT_DEF = 64;

  // One buffered host request.
  typedef struct packed {
    logic              we;
    logic [ARB_AW-1:0] addr;
    logic [ARB_DW-1:0] wdata;
  } req_t;

endpackage

// File: rtl/arb_req_fifo.sv
// Two-entry request FIFO for the host port. Head entry is visible
// combinationally so the arbiter can issue it in the same cycle.
module arb_req_fifo
  import dmem_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  req_t               i_data,
  input  logic               i_pop,
  output req_t               o_head,
  output logic               o_full,
  output logic               o_empty,
  output logic [FIFO_CW-1:0] o_count
);

  req_t               r_mem [FIFO_DEPTH];
  logic [FIFO_PW-1:0] r_wr_ptr;
  logic [FIFO_PW-1:0] r_rd_ptr;
  logic [FIFO_CW-1:0] r_count;
  logic               w_push;
  logic               w_pop;

  assign o_full  = (r_count == FIFO_CW'(FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Pointer and occupancy bookkeeping; push and pop together keep the count.
  // NOTE: state registers use <= so every flop samples pre-edge values; = here
  // would make the result depend on statement order and mis-simulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_PW'(1);
      r_count <= r_count + FIFO_CW'(w_push) - FIFO_CW'(w_pop);
    end
  end

  // Entry storage write.
  // NOTE: storage is deliberately not reset; the count/pointers already mark
  // every slot invalid, and leaving data flops reset-free keeps them plain.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU MM stage (absolute
// priority, zero added latency) and a buffered host port that fills idle
// memory cycles. Also tracks host read ownership, starvation and completions.
// The FIFO entry layout comes from dmem_arb_pkg, so AW/DW must match it.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW           = ARB_AW,
  parameter int DW           = ARB_DW,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_re,
  input  logic             cpu_we,
  input  logic [AW-1:0]    cpu_addr,
  input  logic [DW-1:0]    cpu_wdata,
  output logic [DW-1:0]    cpu_rdata,
  input  logic             h_valid,
  output logic             h_ready,
  input  logic             h_we,
  input  logic [AW-1:0]    h_addr,
  input  logic [DW-1:0]    h_wdata,
  output logic             h_rvalid,
  output logic [DW-1:0]    h_rdata,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_in,
  output logic             mem_we,
  input  logic [DW-1:0]    mem_out,
  output logic             starve,
  output logic [CNT_W-1:0] h_done_cnt
);

  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  logic               w_cpu_busy;
  logic               w_issue;
  logic               w_push;
  logic               w_full;
  logic               w_empty;
  req_t               w_req_in;
  req_t               w_head;
  logic [FIFO_CW-1:0] w_count;
  logic [FIFO_CW-1:0] w_count_next;
  logic [WAIT_W-1:0]  w_wait_next;

  logic               r_h_ready;
  logic               r_rd_owner;
  logic               r_starve;
  logic [AW-1:0]      r_last_addr;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic [CNT_W-1:0]   r_done_cnt;

  assign w_cpu_busy = cpu_re | cpu_we;
  assign w_issue    = !w_cpu_busy && !w_empty;
  assign w_push     = h_valid && r_h_ready && !w_full;

  assign w_req_in.we    = h_we;
  assign w_req_in.addr  = h_addr;
  assign w_req_in.wdata = h_wdata;

  arb_req_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_req_in),
    .i_pop   (w_issue),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_count_next = w_count + FIFO_CW'(w_push) - FIFO_CW'(w_issue);

  // Memory-side mux: CPU first, else FIFO head, else park on the last address.
  // NOTE: every output gets a default before the branches; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    mem_addr = r_last_addr;
    mem_in   = w_head.wdata;
    mem_we   = 1'b0;
    if (w_cpu_busy) begin
      mem_addr = cpu_addr;
      mem_in   = cpu_wdata;
      mem_we   = cpu_we;
    end else if (w_issue) begin
      mem_addr = w_head.addr;
      mem_in   = w_head.wdata;
      mem_we   = w_head.we;
    end
  end

  // Starvation wait counter: counts CPU-blocked cycles with work queued.
  always_comb begin
    w_wait_next = r_wait_cnt;
    if (w_issue || w_empty) begin
      w_wait_next = '0;
    end else if (w_cpu_busy && (r_wait_cnt != WAIT_W'(STARVE_LIMIT))) begin
      w_wait_next = r_wait_cnt + WAIT_W'(1);
    end
  end

  // Control state: ready, read ownership, starvation, completions, parked address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_ready   <= 1'b0;
      r_rd_owner  <= 1'b0;
      r_starve    <= 1'b0;
      r_last_addr <= '0;
      r_wait_cnt  <= '0;
      r_done_cnt  <= '0;
    end else begin
      r_h_ready   <= (w_count_next < FIFO_CW'(FIFO_DEPTH));
      r_rd_owner  <= w_issue && !w_head.we;
      r_last_addr <= mem_addr;
      r_wait_cnt  <= w_wait_next;
      if (w_wait_next == WAIT_W'(STARVE_LIMIT)) r_starve <= 1'b1;
      if (w_issue) r_done_cnt <= r_done_cnt + CNT_W'(1);
    end
  end

  // Memory output is registered upstream, so read data passes straight through.
  assign cpu_rdata  = mem_out;
  assign h_rvalid   = r_rd_owner;
  assign h_rdata    = r_rd_owner ? mem_out : '0;
  assign h_ready    = r_h_ready;
  assign starve     = r_starve;
  assign h_done_cnt = r_done_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a behavioural registered memory, directed
// host/CPU stimulus, and monitors that pop expected host writes and read data.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_re, cpu_we;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        h_valid, h_ready, h_we;
  logic [11:0] h_addr;
  logic [31:0] h_wdata;
  logic        h_rvalid;
  logic [31:0] h_rdata;
  logic [11:0] mem_addr;
  logic [31:0] mem_in;
  logic        mem_we;
  logic [31:0] mem_out;
  logic        starve;
  logic [3:0]  h_done_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [43:0] wq [$];  // expected host writes {addr, data}
  logic [31:0] rq [$];  // expected host read data
  logic [31:0] mem [0:4095];

  dmem_arbiter #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .h_valid(h_valid), .h_ready(h_ready), .h_we(h_we),
    .h_addr(h_addr), .h_wdata(h_wdata),
    .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .mem_addr(mem_addr), .mem_in(mem_in), .mem_we(mem_we), .mem_out(mem_out),
    .starve(starve), .h_done_cnt(h_done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory with registered read (read-before-write).
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_in;
    mem_out <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got no event, required one", name);
  endtask

  // Present one host request and hold it until accepted; returns at posedge+1.
  task automatic host_send(input logic we, input logic [11:0] a, input logic [31:0] d);
    bit ok = 1'b0;
    h_valid = 1'b1; h_we = we; h_addr = a; h_wdata = d;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (h_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    h_valid = 1'b0;
    if (!ok) fail("host_accept_timeout");
  endtask

  // Host-write monitor: a memory write while the CPU is idle must be the next queued host write.
  always @(negedge clk) begin
    if (!rst && mem_we && !cpu_re && !cpu_we) begin
      if (wq.size() == 0) begin
        fail("unexpected_host_write");
      end else begin
        logic [43:0] e;
        e = wq.pop_front();
        check("host_wr_addr", {20'd0, mem_addr}, {20'd0, e[43:32]});
        check("host_wr_data", mem_in, e[31:0]);
      end
    end
  end

  // Host-read monitor: every h_rvalid pulse consumes the next expected read word.
  always @(negedge clk) begin
    if (!rst && h_rvalid) begin
      if (rq.size() == 0) begin
        fail("unexpected_h_rvalid");
      end else begin
        logic [31:0] e;
        e = rq.pop_front();
        check("host_rd_data", h_rdata, e);
      end
    end
  end

  initial begin
    int cnt;
    rst = 1'b1;
    cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    h_valid = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
    mem_out = '0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[0] = 32'h0000_0011;
    mem[1] = 32'h0000_0022;

    // Reset values
    #3;
    check("rst_h_ready",  {31'd0, h_ready},  32'd0);
    check("rst_h_rvalid", {31'd0, h_rvalid}, 32'd0);
    check("rst_starve",   {31'd0, starve},   32'd0);
    check("rst_done_cnt", {28'd0, h_done_cnt}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("h_ready_before_edge", {31'd0, h_ready}, 32'd0);
    @(posedge clk); #1;
    check("h_ready_after_edge", {31'd0, h_ready}, 32'd1);

    // Reset mid-transaction: buffered host write is discarded
    cpu_re = 1'b1; cpu_addr = 12'h200;
    host_send(1'b1, 12'h123, 32'hBAD0_BAD0);
    #2; rst = 1'b1; #1;
    check("midrst_h_ready",  {31'd0, h_ready},  32'd0);
    check("midrst_h_rvalid", {31'd0, h_rvalid}, 32'd0);
    check("midrst_starve",   {31'd0, starve},   32'd0);
    check("midrst_done_cnt", {28'd0, h_done_cnt}, 32'd0);
    cpu_re = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_we) cnt++;
    end
    check("buffered_never_issued", cnt, 32'd0);
    @(posedge clk); #1;

    // CPU priority: 3 CPU stores to 0x010 while host writes the same address
    cpu_we = 1'b1; cpu_addr = 12'h010; cpu_wdata = 32'h1111_1111;
    h_valid = 1'b1; h_we = 1'b1; h_addr = 12'h010; h_wdata = 32'hDEAD_BEEF;
    wq.push_back({12'h010, 32'hDEAD_BEEF});
    @(posedge clk); #1; h_valid = 1'b0;
    @(negedge clk);
    check("cpu_prio_mem_in", mem_in, 32'h1111_1111);
    check("cpu_prio_mem_we", {31'd0, mem_we}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1; cpu_we = 1'b0;
    @(negedge clk);
    check("host_wr_cycle4_we",   {31'd0, mem_we}, 32'd1);
    check("host_wr_cycle4_addr", {20'd0, mem_addr}, 32'h010);
    @(posedge clk); #1;
    rq.push_back(32'hDEAD_BEEF);
    host_send(1'b0, 12'h010, 32'd0);
    @(negedge clk);
    check("rd_issue_rvalid_low", {31'd0, h_rvalid}, 32'd0);
    check("rd_issue_addr", {20'd0, mem_addr}, 32'h010);
    @(negedge clk);
    check("rd_latency_rvalid", {31'd0, h_rvalid}, 32'd1);
    check("rd_after_wr_data", h_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;

    // FIFO full: CPU holds memory, third host request must wait
    cpu_re = 1'b1; cpu_addr = 12'h020;
    wq.push_back({12'h030, 32'hA1A1_A1A1});
    host_send(1'b1, 12'h030, 32'hA1A1_A1A1);
    wq.push_back({12'h031, 32'hA2A2_A2A2});
    host_send(1'b1, 12'h031, 32'hA2A2_A2A2);
    h_valid = 1'b1; h_we = 1'b1; h_addr = 12'h032; h_wdata = 32'hA3A3_A3A3;
    wq.push_back({12'h032, 32'hA3A3_A3A3});
    @(negedge clk);
    check("fifo_full_ready", {31'd0, h_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("fifo_full_ready_held", {31'd0, h_ready}, 32'd0);
    @(posedge clk); #1; cpu_re = 1'b0;
    host_send(1'b1, 12'h032, 32'hA3A3_A3A3);
    repeat (4) @(posedge clk); #1;
    check("done_after_full", {28'd0, h_done_cnt}, 32'd5);

    // Back-to-back host reads, then a CPU load
    rq.push_back(32'h0000_0011);
    rq.push_back(32'h0000_0022);
    host_send(1'b0, 12'h000, 32'd0);
    host_send(1'b0, 12'h001, 32'd0);
    @(negedge clk);
    check("rb_first_rvalid", {31'd0, h_rvalid}, 32'd1);
    check("rb_first_data", h_rdata, 32'h0000_0011);
    @(posedge clk); #1; cpu_re = 1'b1; cpu_addr = 12'h000;
    @(negedge clk);
    check("rb_second_rvalid", {31'd0, h_rvalid}, 32'd1);
    check("rb_second_data", h_rdata, 32'h0000_0022);
    @(posedge clk); #1; cpu_re = 1'b0;
    @(negedge clk);
    check("cpu_load_data", cpu_rdata, 32'h0000_0011);
    check("cpu_load_no_rvalid", {31'd0, h_rvalid}, 32'd0);
    @(posedge clk); #1;

    // Starvation: 70 CPU-busy cycles with one queued request
    cpu_re = 1'b1; cpu_addr = 12'h040;
    wq.push_back({12'h050, 32'hCAFE_F00D});
    host_send(1'b1, 12'h050, 32'hCAFE_F00D);
    repeat (63) @(posedge clk);
    @(negedge clk);
    check("starve_at_63", {31'd0, starve}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("starve_at_64", {31'd0, starve}, 32'd1);
    repeat (6) @(posedge clk);
    #1; cpu_re = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("starve_sticky", {31'd0, starve}, 32'd1);
    check("done_before_wrap", {28'd0, h_done_cnt}, 32'd8);

    // Counter wrap from a fresh reset: 17 writes with CNT_W=4
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    check("starve_cleared", {31'd0, starve}, 32'd0);
    for (int i = 0; i < 17; i++) begin
      wq.push_back({12'h100 + 12'(i), 32'hA000_0000 + 32'(i)});
      host_send(1'b1, 12'h100 + 12'(i), 32'hA000_0000 + 32'(i));
    end
    repeat (3) @(posedge clk); #1;
    check("done_wrap", {28'd0, h_done_cnt}, 32'd1);
    rq.push_back(32'hA000_0005);
    host_send(1'b0, 12'h105, 32'd0);

    // Drain the scoreboards
    cnt = 0;
    while ((wq.size() != 0 || rq.size() != 0) && cnt < 100) begin
      @(posedge clk);
      cnt++;
    end
    @(negedge clk);
    @(negedge clk);
    if (wq.size() != 0 || rq.size() != 0) fail("scoreboard_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port 4096-word data memory between the pipelined CPU's MM-stage access and a host/loader port (UART loader, debug reader).
- The CPU has absolute priority and sees zero added latency, because the pipeline cannot stall.
- Host requests are buffered in a 2-entry FIFO and issued in cycles where the CPU does not touch memory.
- Read data returns one cycle after issue, matching the memory's registered output.

Parameters:
AW, 12, word-address width (memory depth 2**AW)
DW, 32, data width
STARVE_LIMIT, 64, consecutive host-blocked cycles before the starve flag sets
CNT_W, 16, width of the host-completion counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cpu_re  in  1  CPU load in MM stage (already qualified by valid)
cpu_we  in  1  CPU store in MM stage (already qualified by valid)
cpu_addr  in  AW  CPU word address
cpu_wdata  in  DW  CPU store data
cpu_rdata  out  DW  load data, valid the cycle after cpu_re (WA stage)
h_valid  in  1  host request valid
h_ready  out  1  host request accepted when h_valid && h_ready
h_we  in  1  1 = write, 0 = read
h_addr  in  AW  host word address
h_wdata  in  DW  host write data
h_rvalid  out  1  host read data valid (single-cycle pulse, no backpressure)
h_rdata  out  DW  host read data
mem_addr  out  AW  to memory address
mem_in  out  DW  to memory write data
mem_we  out  1  to memory write enable
mem_out  in  DW  from memory; registered, valid one cycle after mem_addr
starve  out  1  sticky: host starved STARVE_LIMIT cycles
h_done_cnt  out  CNT_W  count of issued host operations; wraps

Behaviour:
- Reset (async) values: FIFO empty, h_ready=0, h_rvalid=0, h_rdata=0, starve=0, h_done_cnt=0, rd_owner=0. h_ready is registered and goes to 1 on the first clk edge after rst deasserts. Reset mid-transaction discards the buffered requests and any pending read response.
- cpu_busy = cpu_re | cpu_we.
- Memory-side mux is combinational:
  - If cpu_busy: mem_addr=cpu_addr, mem_in=cpu_wdata, mem_we=cpu_we.
  - Else if FIFO non-empty: drive the head entry, mem_we=head.we, and pop the head (issue).
  - Else: mem_addr holds the last driven value, mem_we=0.
- cpu_rdata = mem_out, passed through combinationally. The CPU ignores it when it did not load.
- Read tracking: rd_owner_q <= issue && !head.we. The next cycle, h_rvalid=rd_owner_q and h_rdata=mem_out (registered capture not permitted; same-cycle pass-through).
- FIFO: 2 entries of {we, addr, wdata}.
  - h_ready=!full (registered form: next-state count<2, or count==2 with a pop this cycle).
  - Push and pop in the same cycle leave the count unchanged.
  - Entries issue strictly in order, so a host read after a host write to the same address returns the new data.
  - No ordering between the CPU and host ports. A same-cycle CPU store and queued host write to the same address resolve as CPU first, host later.
- Starvation:
  - wait_cnt increments each cycle where the FIFO is non-empty and cpu_busy=1.
  - wait_cnt clears on any issue or when the FIFO is empty, and saturates at STARVE_LIMIT.
  - starve sets when wait_cnt reaches STARVE_LIMIT and clears only on rst.
- h_done_cnt increments by 1 per issue and wraps at 2**CNT_W.
- Host must always accept h_rvalid. Read responses are in issue order.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - request entry layout {we, addr, wdata} with AW/DW constants
  - FIFO_DEPTH=2
  - default STARVE_LIMIT
- Sub-module arb_req_fifo: 2-entry synchronous FIFO with async reset, push/pop/full/empty/count, head outputs combinational.
- Arbitration, read tracking and counters stay in dmem_arbiter.

Test Plan:
- Reset: assert rst mid-cycle with a host request buffered → h_ready=0, h_rvalid=0, starve=0, h_done_cnt=0 immediately. h_ready=1 one edge after release; the buffered request is never issued (mem_we stays 0).
- CPU priority: cpu_we=1 at addr 0x010 for 3 cycles while the host writes 0xDEADBEEF to 0x010 → host write issues in cycle 4 (mem_we, mem_addr=0x010). A host read of 0x010 then returns h_rdata=0xDEADBEEF, h_rvalid one cycle after issue.
- FIFO full: cpu_re held 1; host presents 3 requests back-to-back → h_ready drops after 2 accepts. After cpu_re drops, the 2 requests issue on consecutive cycles, then the 3rd is accepted. h_done_cnt=3.
- Interleaved read-back: host reads 0x000, 0x001 with memory preloaded to 0x11, 0x22 and CPU idle → h_rvalid pulses on two consecutive cycles carrying 0x11 then 0x22. cpu_re on a third cycle gives cpu_rdata the next cycle with h_rvalid=0.
- Starvation: cpu_re=1 for 70 cycles with one host request queued → starve rises exactly at wait cycle 64 and stays 1 after the request issues.
- Counter wrap: CNT_W=4, 17 host writes → h_done_cnt=1.
